// File: rtl/tx_arb_10ge_if.sv
// One 32-bit AXI-Stream channel of the tester TX path (data, keep, last, CRC-append and error sidebands).
interface tx_arb_10ge_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;
  logic [3:0]  tkeep;
  logic        tcrc;
  logic        terr;

  modport master (output tvalid, tdata, tlast, tkeep, tcrc, terr, input  tready);
  modport slave  (input  tvalid, tdata, tlast, tkeep, tcrc, terr, output tready);
endinterface

// File: rtl/tx_arb_10ge.sv
// Frame-granular round-robin arbiter s0/s1 -> 10GE MAC TX; 1-cycle grant, then zero-latency pass-through with tready mirrored.
// Length watchdog truncates frames at MAX_BEATS (tlast+terr forced) and drains the source; TX_ARB_STATS_EN adds frame/trunc counters.
module tx_arb_10ge #(
  parameter int MAX_BEATS = 384
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  tx_arb_10ge_if.slave  s0_axis,
  tx_arb_10ge_if.slave  s1_axis,
  tx_arb_10ge_if.master m_axis,
  output logic busy,
  output logic gnt_id,
  output logic trunc_pulse
`ifdef TX_ARB_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [31:0] frm_cnt0,
  output logic [31:0] frm_cnt1,
  output logic [15:0] trunc_cnt
`endif
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_BEATS - 1);

  typedef enum logic [2:0] {IDLE, PASS0, PASS1, DRAIN0, DRAIN1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             last_gnt_q, last_gnt_d;
  logic             gnt_id_q, gnt_id_d;
  logic             trunc_q, trunc_d;
  logic             frm_done, pick;

  logic        src_sel, src_vld, src_last, src_err, src_crc, src_rdy;
  logic [31:0] src_dat;
  logic [3:0]  src_keep;
  logic        pass, drain, at_limit, trunc_beat, acc;

  // Both PASS and DRAIN of source 1 select the s1 stream.
  assign src_sel  = (state_q == PASS1) || (state_q == DRAIN1);
  assign src_vld  = src_sel ? s1_axis.tvalid : s0_axis.tvalid;
  assign src_dat  = src_sel ? s1_axis.tdata  : s0_axis.tdata;
  assign src_last = src_sel ? s1_axis.tlast  : s0_axis.tlast;
  assign src_keep = src_sel ? s1_axis.tkeep  : s0_axis.tkeep;
  assign src_crc  = src_sel ? s1_axis.tcrc   : s0_axis.tcrc;
  assign src_err  = src_sel ? s1_axis.terr   : s0_axis.terr;

  assign pass       = (state_q == PASS0) || (state_q == PASS1);
  assign drain      = (state_q == DRAIN0) || (state_q == DRAIN1);
  assign at_limit   = (beat_cnt_q == LIMIT);
  assign trunc_beat = pass && at_limit && !src_last;
  assign src_rdy    = pass ? m_axis.tready : drain;
  assign acc        = src_vld && src_rdy;

  assign m_axis.tvalid = pass && src_vld;
  assign m_axis.tdata  = pass ? src_dat  : '0;
  assign m_axis.tkeep  = pass ? src_keep : '0;
  assign m_axis.tcrc   = pass && src_crc;
  assign m_axis.tlast  = pass && (src_last || trunc_beat);
  assign m_axis.terr   = pass && (src_err || trunc_beat);
  assign s0_axis.tready = !src_sel && src_rdy;
  assign s1_axis.tready = src_sel && src_rdy;

  assign busy        = (state_q != IDLE);
  assign gnt_id      = gnt_id_q;
  assign trunc_pulse = trunc_q;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    last_gnt_d = last_gnt_q;
    gnt_id_d   = gnt_id_q;
    trunc_d    = 1'b0;
    frm_done   = 1'b0;
    pick       = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_en && (s0_axis.tvalid || s1_axis.tvalid)) begin
          pick       = (s0_axis.tvalid && s1_axis.tvalid) ? !last_gnt_q : s1_axis.tvalid;
          state_d    = pick ? PASS1 : PASS0;
          last_gnt_d = pick;
          gnt_id_d   = pick;
        end
      end
      PASS0, PASS1: begin
        if (acc) begin
          // A tlast landing on the limit beat is a normal end, so tlast is tested first.
          if (src_last) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            frm_done   = 1'b1;
          end else if (at_limit) begin
            state_d    = src_sel ? DRAIN1 : DRAIN0;
            beat_cnt_d = '0;
            trunc_d    = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN0, DRAIN1: begin
        if (acc && src_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      last_gnt_q <= 1'b1;
      gnt_id_q   <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      last_gnt_q <= last_gnt_d;
      gnt_id_q   <= gnt_id_d;
      trunc_q    <= trunc_d;
    end
  end

`ifdef TX_ARB_STATS_EN
  logic [31:0] frm_cnt0_q, frm_cnt0_d, frm_cnt1_q, frm_cnt1_d;
  logic [15:0] trunc_cnt_q, trunc_cnt_d;

  always_comb begin
    frm_cnt0_d  = frm_cnt0_q;
    frm_cnt1_d  = frm_cnt1_q;
    trunc_cnt_d = trunc_cnt_q;
    if (stats_clr) begin
      frm_cnt0_d  = '0;
      frm_cnt1_d  = '0;
      trunc_cnt_d = '0;
    end else begin
      if (frm_done && !src_sel) frm_cnt0_d = frm_cnt0_q + 32'd1;
      if (frm_done && src_sel)  frm_cnt1_d = frm_cnt1_q + 32'd1;
      if (trunc_d)              trunc_cnt_d = trunc_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_cnt0_q  <= '0;
      frm_cnt1_q  <= '0;
      trunc_cnt_q <= '0;
    end else begin
      frm_cnt0_q  <= frm_cnt0_d;
      frm_cnt1_q  <= frm_cnt1_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  assign frm_cnt0  = frm_cnt0_q;
  assign frm_cnt1  = frm_cnt1_q;
  assign trunc_cnt = trunc_cnt_q;
`endif
endmodule

// File: tb/tb_tx_arb_10ge.sv
// Scoreboard bench for tx_arb_10ge (MAX_BEATS=8): source queues drive s0/s1, expected m_axis beats are queued at push time.
module tb_tx_arb_10ge;
  localparam int MAXB = 8;

  logic clk = 1'b0;
  logic rst, arb_en;
  logic busy, gnt_id, trunc_pulse;
`ifdef TX_ARB_STATS_EN
  logic        stats_clr;
  logic [31:0] frm_cnt0, frm_cnt1;
  logic [15:0] trunc_cnt;
`endif

  always #5 clk = ~clk;

  tx_arb_10ge_if s0_if ();
  tx_arb_10ge_if s1_if ();
  tx_arb_10ge_if m_if ();

  tx_arb_10ge #(.MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en),
    .s0_axis(s0_if), .s1_axis(s1_if), .m_axis(m_if),
    .busy(busy), .gnt_id(gnt_id), .trunc_pulse(trunc_pulse)
`ifdef TX_ARB_STATS_EN
    , .stats_clr(stats_clr), .frm_cnt0(frm_cnt0), .frm_cnt1(frm_cnt1), .trunc_cnt(trunc_cnt)
`endif
  );

  typedef struct packed {logic [31:0] d; logic l; logic [3:0] k; logic c; logic e;} beat_t;
  typedef struct packed {logic src; beat_t b;} exp_t;

  beat_t sq0[$];
  beat_t sq1[$];
  exp_t  expq[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Source drivers: acceptance sampled at negedge, next beat presented just after posedge.
  initial begin : drv0
    bit acc0;
    s0_if.tvalid = 1'b0;
    {s0_if.tdata, s0_if.tlast, s0_if.tkeep, s0_if.tcrc, s0_if.terr} = '0;
    forever begin
      @(negedge clk);
      acc0 = s0_if.tvalid && s0_if.tready;
      @(posedge clk); #1;
      if (acc0 && sq0.size() > 0) void'(sq0.pop_front());
      if (sq0.size() > 0) begin
        s0_if.tvalid = 1'b1;
        {s0_if.tdata, s0_if.tlast, s0_if.tkeep, s0_if.tcrc, s0_if.terr} = sq0[0];
      end else begin
        s0_if.tvalid = 1'b0;
        {s0_if.tdata, s0_if.tlast, s0_if.tkeep, s0_if.tcrc, s0_if.terr} = '0;
      end
    end
  end

  initial begin : drv1
    bit acc1;
    s1_if.tvalid = 1'b0;
    {s1_if.tdata, s1_if.tlast, s1_if.tkeep, s1_if.tcrc, s1_if.terr} = '0;
    forever begin
      @(negedge clk);
      acc1 = s1_if.tvalid && s1_if.tready;
      @(posedge clk); #1;
      if (acc1 && sq1.size() > 0) void'(sq1.pop_front());
      if (sq1.size() > 0) begin
        s1_if.tvalid = 1'b1;
        {s1_if.tdata, s1_if.tlast, s1_if.tkeep, s1_if.tcrc, s1_if.terr} = sq1[0];
      end else begin
        s1_if.tvalid = 1'b0;
        {s1_if.tdata, s1_if.tlast, s1_if.tkeep, s1_if.tcrc, s1_if.terr} = '0;
      end
    end
  end

  // Output monitor: every accepted m_axis beat is popped against the scoreboard.
  initial begin : mon
    exp_t  e;
    beat_t got;
    forever begin
      @(negedge clk);
      if (!rst && m_if.tvalid && m_if.tready) begin
        got = {m_if.tdata, m_if.tlast, m_if.tkeep, m_if.tcrc, m_if.terr};
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat got=%h gnt=%0d (none expected)", got, gnt_id);
        end else begin
          e = expq.pop_front();
          if (got !== e.b || gnt_id !== e.src) begin
            n_fail++;
            $display("FAIL beat got=%h gnt=%0d expected=%h gnt=%0d", got, gnt_id, e.b, e.src);
          end
        end
      end
    end
  end

  // Queue an n-beat frame; trunc_at>0 means only trunc_at beats reach the MAC, the last one with tlast+terr.
  task automatic push_frame(input bit src, input int n, input int fid, input int trunc_at, input int err_beat);
    beat_t b;
    exp_t  e;
    logic [7:0] f8, i8;
    f8 = fid[7:0];
    for (int i = 0; i < n; i++) begin
      i8  = i[7:0];
      b.d = {(src ? 8'hB1 : 8'hA0), f8, 8'h5C, i8};
      b.l = (i == n - 1);
      b.k = (i == n - 1) ? 4'b0011 : 4'b1111;
      b.c = (i == n - 1);
      b.e = (i == err_beat);
      if (src) sq1.push_back(b); else sq0.push_back(b);
      if (trunc_at == 0 || i < trunc_at) begin
        e.src = src;
        e.b   = b;
        if (trunc_at > 0 && i == trunc_at - 1) begin
          e.b.l = 1'b1;
          e.b.e = 1'b1;
        end
        expq.push_back(e);
      end
    end
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (sq0.size() == 0 && sq1.size() == 0 && expq.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; arb_en = 1'b0; m_if.tready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (gnt_id !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got=%b want=0", gnt_id); end
    n_checks++; if (trunc_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_trunc got=%b want=0", trunc_pulse); end
    n_checks++;
    if ({m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tkeep, m_if.tcrc, m_if.terr} !== 40'd0) begin
      n_fail++; $display("FAIL reset_m got=%h want=0", {m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tkeep, m_if.tcrc, m_if.terr});
    end
    n_checks++;
    if ({s0_if.tready, s1_if.tready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_tready got=%b want=00", {s0_if.tready, s1_if.tready});
    end
    #1 rst = 1'b0; arb_en = 1'b1; m_if.tready = 1'b1;
  endtask

  task automatic test_single();
    int nb, first;
    bit v0, v1, ok;
    nb = 0; first = -1; v0 = 1'b0; v1 = 1'b0;
    @(negedge clk); #1;
    push_frame(1'b0, 4, 1, 0, -1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) v0 = m_if.tvalid;
      if (i == 1) v1 = m_if.tvalid;
      if (busy) begin nb++; if (first < 0) first = i; end
    end
    n_checks++; if (first != 1) begin n_fail++; $display("FAIL single_grant_cycle got=%0d want=1", first); end
    n_checks++; if (nb != 4) begin n_fail++; $display("FAIL single_busy_cycles got=%0d want=4", nb); end
    n_checks++; if ({v0, v1} !== 2'b01) begin n_fail++; $display("FAIL single_first_valid got=%b want=01", {v0, v1}); end
    wait_done(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_done got=pending want=idle"); end
  endtask

  task automatic test_contention();
    bit ok;
    @(negedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    for (int f = 0; f < 3; f++) begin
      push_frame(1'b0, 2, 16 + f, 0, -1);
      push_frame(1'b1, 2, 32 + f, 0, -1);
    end
    wait_done(80, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL contention_done got=pending want=idle left=%0d", expq.size()); end
  endtask

  task automatic test_backpressure();
    int nbad, nseen;
    bit ok;
    nbad = 0; nseen = 0;
    @(negedge clk); #1;
    push_frame(1'b1, 5, 48, 0, -1);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      m_if.tready = (c % 2 == 0);
      @(negedge clk);
      if (busy) begin
        nseen++;
        if (s1_if.tready !== m_if.tready || s0_if.tready !== 1'b0) nbad++;
      end
      if (expq.size() == 0 && !busy) break;
    end
    m_if.tready = 1'b1;
    n_checks++; if (nbad != 0 || nseen < 9) begin n_fail++; $display("FAIL bp_tready_mirror got=%0d_bad/%0d want=0_bad/>=9", nbad, nseen); end
    wait_done(20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_done got=pending want=idle"); end
  endtask

  task automatic test_watchdog();
    int ntr, nbad;
    bit ok;
    ntr = 0; nbad = 0;
    @(negedge clk); #1;
    push_frame(1'b0, 12, 64, MAXB, -1);
    push_frame(1'b1, 2, 65, 0, -1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (trunc_pulse) begin
        ntr++;
        if (m_if.tvalid !== 1'b0 || s0_if.tready !== 1'b1) nbad++;
      end
      if (sq0.size() == 0 && sq1.size() == 0 && expq.size() == 0 && !busy) break;
    end
    n_checks++; if (ntr != 1) begin n_fail++; $display("FAIL wd_trunc_pulses got=%0d want=1", ntr); end
    n_checks++; if (nbad != 0) begin n_fail++; $display("FAIL wd_drain_state got=%0d_bad want=0", nbad); end
    wait_done(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wd_done got=pending want=idle"); end
  endtask

  task automatic test_exact_limit();
    int ntr;
    bit ok;
    ntr = 0;
    @(negedge clk); #1;
    push_frame(1'b0, MAXB, 80, 0, 2);
    push_frame(1'b1, 1, 81, 0, -1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (trunc_pulse) ntr++;
      if (sq0.size() == 0 && sq1.size() == 0 && expq.size() == 0 && !busy) break;
    end
    n_checks++; if (ntr != 0) begin n_fail++; $display("FAIL exact_trunc_pulses got=%0d want=0", ntr); end
    wait_done(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL exact_done got=pending want=idle"); end
  endtask

  task automatic test_arb_en_rst();
    int nbad;
    bit ok, seen;
    nbad = 0; seen = 1'b0;
    @(negedge clk); #1;
    push_frame(1'b0, 4, 96, 0, -1);
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = busy; end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL en_grant got=idle want=busy"); end
    #1 arb_en = 1'b0;
    push_frame(1'b1, 2, 97, 0, -1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (expq.size() == 2 && !busy) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL en_frame_finish got=pending left=%0d want=2", expq.size()); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || s1_if.tready || m_if.tvalid) nbad++;
    end
    n_checks++; if (nbad != 0) begin n_fail++; $display("FAIL en_hold_idle got=%0d_active want=0", nbad); end
    #1 arb_en = 1'b1;
    wait_done(20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL en_resume got=pending want=idle"); end

    @(negedge clk); #1;
    push_frame(1'b1, 6, 98, 0, -1);
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (expq.size() <= 4) break; end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({m_if.tvalid, m_if.tdata, m_if.tlast, m_if.terr, s0_if.tready, s1_if.tready, busy, gnt_id} !== 40'd0) begin
      n_fail++; $display("FAIL rst_midframe got=%h want=0", {m_if.tvalid, m_if.tdata, m_if.tlast, m_if.terr, s0_if.tready, s1_if.tready, busy, gnt_id});
    end
    sq0.delete(); sq1.delete(); expq.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    push_frame(1'b0, 1, 99, 0, -1);
    push_frame(1'b1, 1, 100, 0, -1);
    wait_done(20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_tie_done got=pending want=idle"); end
  endtask

`ifdef TX_ARB_STATS_EN
  task automatic test_stats();
    bit ok;
    n_checks++;
    if (frm_cnt0 !== 32'd1 || frm_cnt1 !== 32'd1 || trunc_cnt !== 16'd0) begin
      n_fail++; $display("FAIL stats_frames got=%0d/%0d/%0d want=1/1/0", frm_cnt0, frm_cnt1, trunc_cnt);
    end
    @(negedge clk); #1;
    push_frame(1'b0, MAXB + 1, 112, MAXB, -1);
    wait_done(40, ok);
    n_checks++;
    if (!ok || frm_cnt0 !== 32'd1 || trunc_cnt !== 16'd1) begin
      n_fail++; $display("FAIL stats_trunc got=%0d/%0d ok=%0d want=1/1 ok=1", frm_cnt0, trunc_cnt, ok);
    end
    #1 stats_clr = 1'b1;
    @(negedge clk);
    #1 stats_clr = 1'b0;
    n_checks++;
    if (frm_cnt0 !== 32'd0 || frm_cnt1 !== 32'd0 || trunc_cnt !== 16'd0) begin
      n_fail++; $display("FAIL stats_clr got=%0d/%0d/%0d want=0/0/0", frm_cnt0, frm_cnt1, trunc_cnt);
    end
  endtask
`endif

  initial begin
`ifdef TX_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_watchdog();
    test_exact_limit();
    test_arb_en_rst();
`ifdef TX_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule
